axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a simple one-at-a-time command interface into single
// AXI4-Lite read or write transactions, with a per-transaction watchdog.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_we/cmd_addr/cmd_wdata  command: direction, byte address, write data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata/rsp_status       read data, {timeout, xRESP[1:0]}
//   M_AXI_AW*/W*/B*            AXI4-Lite write address/data/response channels
//   M_AXI_AR*/R*               AXI4-Lite read address/data channels
module axil_cmd_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [2:0]                      rsp_status,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned DW        = C_M_AXI_DATA_WIDTH;
  localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned SW        = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WDOG_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_rsp_valid;
  logic [DW-1:0]       r_rsp_rdata;
  logic [2:0]          r_rsp_status;
  logic [WDOG_W-1:0]   r_wdog;

  logic                w_busy;
  logic                w_expire;
  logic                w_hs_now;
  logic                w_timeout;
  logic                w_aw_done;
  logic                w_w_done;

  // Address/data channel completes this cycle if already handshaken or handshaking now
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wdog == WDOG_W'(WDOG_LAST));

  // Any handshake in the expiry cycle wins over the watchdog
  always_comb begin
    w_hs_now = 1'b0;
    case (r_state)
      S_WR_ADDR_DATA: w_hs_now = (r_awvalid && M_AXI_AWREADY) || (r_wvalid && M_AXI_WREADY);
      S_WR_RESP:      w_hs_now = M_AXI_BVALID;
      S_RD_ADDR:      w_hs_now = M_AXI_ARREADY;
      S_RD_DATA:      w_hs_now = M_AXI_RVALID;
      default:        w_hs_now = 1'b0;
    endcase
  end

  assign w_timeout = w_busy && w_expire && !w_hs_now;

  // Transaction FSM; every output comes straight from a register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= 3'b000;
      r_wdog       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;

      // Watchdog saturates at its last value so expiry stays asserted
      if (w_busy && !w_expire) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_wdog      <= '0;
            if (cmd_we) begin
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR_DATA;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end

        S_WR_ADDR_DATA: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready     <= 1'b0;
            r_rsp_status <= {1'b0, M_AXI_BRESP};
            r_rsp_rdata  <= '0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready     <= 1'b0;
            r_rsp_status <= {1'b0, M_AXI_RRESP};
            r_rsp_rdata  <= M_AXI_RDATA;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // Watchdog expiry abandons the bus and reports a timeout
      if (w_timeout) begin
        r_awvalid    <= 1'b0;
        r_wvalid     <= 1'b0;
        r_bready     <= 1'b0;
        r_arvalid    <= 1'b0;
        r_rready     <= 1'b0;
        r_rsp_status <= 3'b100;
        r_rsp_rdata  <= '0;
        r_rsp_valid  <= 1'b1;
        r_state      <= S_DONE;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_status    = r_rsp_status;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = {SW{1'b1}};
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a reactive AXI4-Lite slave model, directed
// commands, and a scoreboard monitor that checks every response pulse.
module tb_axil_cmd_master;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_we    = 1'b0;
  logic [AW-1:0]  cmd_addr  = '0;
  logic [DW-1:0]  cmd_wdata = '0;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic [2:0]     rsp_status;
  logic [AW-1:0]  M_AXI_AWADDR;
  logic [2:0]     M_AXI_AWPROT;
  logic           M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0]  M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic           M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]     M_AXI_BRESP;
  logic           M_AXI_BVALID, M_AXI_BREADY;
  logic [AW-1:0]  M_AXI_ARADDR;
  logic [2:0]     M_AXI_ARPROT;
  logic           M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0]  M_AXI_RDATA;
  logic [1:0]     M_AXI_RRESP;
  logic           M_AXI_RVALID, M_AXI_RREADY;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  int         s_w_delay = 0;     // 0: WREADY like AWREADY; N: WREADY N cycles after AWREADY
  bit         s_b_never = 1'b0;
  bit         s_b_force = 1'b0;
  bit         s_r_never = 1'b0;
  logic [1:0] s_bresp   = 2'b00;
  logic [1:0] s_rresp   = 2'b00;
  logic [DW-1:0] s_rdata = '0;

  logic sl_awready, sl_wready_r, sl_arready, sl_bvalid, sl_rvalid, aw_f, w_f;
  logic [1:0]    sl_bresp, sl_rresp;
  logic [DW-1:0] sl_rdata;
  int            w_cnt;
  logic          aw_hs, w_hs, ar_hs;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

  assign M_AXI_AWREADY = sl_awready;
  assign M_AXI_WREADY  = (s_w_delay == 0) ? sl_wready_r : (M_AXI_WVALID && (w_cnt == 1));
  assign M_AXI_BVALID  = sl_bvalid | s_b_force;
  assign M_AXI_BRESP   = sl_bresp;
  assign M_AXI_ARREADY = sl_arready;
  assign M_AXI_RVALID  = sl_rvalid;
  assign M_AXI_RDATA   = sl_rdata;
  assign M_AXI_RRESP   = sl_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_awready <= 1'b0; sl_wready_r <= 1'b0; sl_arready <= 1'b0;
      sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; aw_f <= 1'b0; w_f <= 1'b0;
      sl_bresp <= 2'b00; sl_rresp <= 2'b00; sl_rdata <= '0; w_cnt <= 0;
    end else begin
      sl_awready  <= M_AXI_AWVALID && !sl_awready;
      sl_wready_r <= M_AXI_WVALID && !sl_wready_r;
      sl_arready  <= M_AXI_ARVALID && !sl_arready;
      if (aw_hs) w_cnt <= s_w_delay;
      else if (w_cnt != 0) w_cnt <= w_cnt - 1;
      if (sl_bvalid && M_AXI_BREADY) sl_bvalid <= 1'b0;
      if ((aw_f || aw_hs) && (w_f || w_hs)) begin
        aw_f <= 1'b0; w_f <= 1'b0;
        if (!s_b_never) begin sl_bvalid <= 1'b1; sl_bresp <= s_bresp; end
      end else begin
        aw_f <= aw_f || aw_hs; w_f <= w_f || w_hs;
      end
      if (ar_hs && !s_r_never) begin
        sl_rvalid <= 1'b1; sl_rdata <= s_rdata; sl_rresp <= s_rresp;
      end else if (sl_rvalid && M_AXI_RREADY) begin
        sl_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic [2:0]    status;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 status=0x%0h, expected no response", rsp_status);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_status", 64'(rsp_status), 64'(mon_e.status));
        check("rsp_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        check("cmd_ready_in_done", 64'(cmd_ready), 64'(0));
      end
    end
  end

  // Issue one command; returns at the negedge of the cycle after acceptance
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input bit expect_rsp, input logic [DW-1:0] exp_rd,
                       input logic [2:0] exp_st, input int exp_lat, output int acc);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL cmd_accept: got cmd_ready=%b after 50 cycles, expected 1", cmd_ready);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (expect_rsp) begin
      e.rdata = exp_rd; e.status = exp_st; e.acc = cyc; e.lat = exp_lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_drain: got %0d responses outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_status", 64'(rsp_status), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_valid_ready",
          64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    // Zero-wait write
    issue(1'b1, 11'h0A5, 32'hDEADBEEF, 1'b1, 32'h0, 3'b000, 4, acc);
    check("wr0_awvalid", 64'(M_AXI_AWVALID), 64'(1));
    check("wr0_wvalid", 64'(M_AXI_WVALID), 64'(1));
    check("wr0_awaddr", 64'(M_AXI_AWADDR), 64'(11'h0A5));
    check("wr0_wdata", 64'(M_AXI_WDATA), 64'(32'hDEADBEEF));
    check("wr0_wstrb", 64'(M_AXI_WSTRB), 64'(4'hF));
    check("wr0_awprot", 64'(M_AXI_AWPROT), 64'(0));
    drain("wr0");

    // Write with WREADY three cycles after AWREADY
    s_w_delay = 3;
    issue(1'b1, 11'h100, 32'h0000_1111, 1'b1, 32'h0, 3'b000, 7, acc);
    check("wr1_c1_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b11));
    @(negedge clk);
    check("wr1_c2_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b11));
    @(negedge clk);
    check("wr1_c3_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b01));
    @(negedge clk);
    check("wr1_c4_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b01));
    @(negedge clk);
    check("wr1_c5_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b01));
    check("wr1_c5_wdata", 64'(M_AXI_WDATA), 64'(32'h0000_1111));
    @(negedge clk);
    check("wr1_c6_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b00));
    drain("wr1");
    s_w_delay = 0;

    // Read with SLVERR
    s_rdata = 32'h12345678; s_rresp = 2'b10;
    issue(1'b0, 11'h010, 32'h0, 1'b1, 32'h12345678, 3'b010, 4, acc);
    check("rd0_arvalid", 64'(M_AXI_ARVALID), 64'(1));
    check("rd0_araddr", 64'(M_AXI_ARADDR), 64'(11'h010));
    check("rd0_arprot", 64'(M_AXI_ARPROT), 64'(0));
    check("rd0_no_aw", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(0));
    drain("rd0");

    // Write with DECERR, then an OKAY read back-to-back
    s_bresp = 2'b11;
    issue(1'b1, 11'h7FC, 32'hA5A5_5A5A, 1'b1, 32'h0, 3'b011, 4, acc);
    drain("wr2");
    s_bresp = 2'b00;
    s_rdata = 32'hCAFEF00D; s_rresp = 2'b00;
    issue(1'b0, 11'h004, 32'h0, 1'b1, 32'hCAFEF00D, 3'b000, 4, acc);
    drain("rd1");

    // Watchdog: BVALID never comes
    s_b_never = 1'b1;
    issue(1'b1, 11'h020, 32'h0000_0055, 1'b1, 32'h0, 3'b100, 17, acc);
    repeat (9) @(negedge clk);
    check("to_bready_waiting", 64'(M_AXI_BREADY), 64'(1));
    drain("to");
    @(negedge clk);
    check("to_bready_dropped", 64'(M_AXI_BREADY), 64'(0));
    s_b_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to_late_bvalid_bready", 64'(M_AXI_BREADY), 64'(0));
    end
    s_b_force = 1'b0;
    s_b_never = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during RD_DATA aborts silently
    s_r_never = 1'b1;
    issue(1'b0, 11'h030, 32'h0, 1'b0, 32'h0, 3'b000, 0, acc);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_rready_before", 64'(M_AXI_RREADY), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rready_async", 64'(M_AXI_RREADY), 64'(0));
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    s_r_never = 1'b0;
    repeat (3) @(negedge clk);
    s_rdata = 32'h0BADC0DE; s_rresp = 2'b00;
    issue(1'b0, 11'h030, 32'h0, 1'b1, 32'h0BADC0DE, 3'b000, 4, acc);
    drain("rd_after_rst");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
